// File: rtl/echo_indication_input.sv
// Two-entry tagged word FIFO feeding the heard indication.
// Words whose tag is not TAG_HEARD are dropped and counted.
module echo_indication_input #(
  parameter int TAG_HEARD  = 1,
  parameter int TAG_WIDTH  = 16,
  parameter int DATA_WIDTH = 32
) (
  input  logic                              CLK,
  input  logic                              RST,
  input  logic                              pipe_enq__ENA,
  input  logic [TAG_WIDTH+2*DATA_WIDTH-1:0] pipe_enq_v,
  output logic                              pipe_enq__RDY,
  output logic                              indication_heard__ENA,
  output logic [DATA_WIDTH-1:0]             indication_heard_meth,
  output logic [DATA_WIDTH-1:0]             indication_heard_v,
  input  logic                              indication_heard__RDY,
  output logic [15:0]                       drop_count
);

  localparam int W = TAG_WIDTH + 2 * DATA_WIDTH;

  logic [W-1:0]  mem_q [2];
  logic [1:0]    valid_q;
  logic [1:0]    valid_d;
  logic          wp_q;
  logic          rp_q;
  logic [15:0]   drop_q;
  logic [15:0]   drop_d;

  logic [W-1:0]  head;
  logic          head_vld;
  logic          head_hit;
  logic          enq;
  logic          heard;
  logic          discard;
  logic          deq;

  assign head     = mem_q[rp_q];
  assign head_vld = valid_q[rp_q];
  assign head_hit = head[W-1 -: TAG_WIDTH] == TAG_WIDTH'(TAG_HEARD);

  assign pipe_enq__RDY = ~&valid_q;
  assign enq           = pipe_enq__ENA & pipe_enq__RDY;
  assign heard         = head_vld & head_hit & indication_heard__RDY;
  assign discard       = head_vld & ~head_hit;
  assign deq           = heard | discard;

  assign indication_heard__ENA = heard;
  assign drop_count            = drop_q;

  // Stored entries are not cleared on dequeue, so gate by valid.
  assign indication_heard_meth =
    head_vld ? head[2*DATA_WIDTH-1 -: DATA_WIDTH] : '0;
  assign indication_heard_v =
    head_vld ? head[DATA_WIDTH-1:0] : '0;

  always_comb begin
    valid_d = valid_q;
    if (deq) valid_d[rp_q] = 1'b0;
    if (enq) valid_d[wp_q] = 1'b1;
  end

  always_comb begin
    drop_d = drop_q;
    if (discard && drop_q != 16'hFFFF)
      drop_d = drop_q + 16'd1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      valid_q  <= 2'b00;
      wp_q     <= 1'b0;
      rp_q     <= 1'b0;
      drop_q   <= 16'd0;
    end else begin
      valid_q <= valid_d;
      drop_q  <= drop_d;
      if (enq) begin
        mem_q[wp_q] <= pipe_enq_v;
        wp_q        <= ~wp_q;
      end
      if (deq) rp_q <= ~rp_q;
    end
  end

endmodule

// File: tb/tb_echo_indication_input.sv
// Scoreboard bench for echo_indication_input.
// Heard words are queued on acceptance and popped on heard__ENA.
module tb_echo_indication_input;

  logic        CLK = 1'b0;
  logic        RST;
  logic        enq_ena;
  logic [79:0] enq_v;
  logic        enq_rdy;
  logic        heard_ena;
  logic [31:0] heard_meth;
  logic [31:0] heard_v;
  logic        heard_rdy;
  logic [15:0] drop_count;

  logic [63:0] sb [$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          heard_cnt = 0;
  logic [15:0] exp_drop = 16'd0;
  logic        acc;
  int          h0;

  echo_indication_input dut (
    .CLK                   (CLK),
    .RST                   (RST),
    .pipe_enq__ENA         (enq_ena),
    .pipe_enq_v            (enq_v),
    .pipe_enq__RDY         (enq_rdy),
    .indication_heard__ENA (heard_ena),
    .indication_heard_meth (heard_meth),
    .indication_heard_v    (heard_v),
    .indication_heard__RDY (heard_rdy),
    .drop_count            (drop_count)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge CLK) begin
    logic [63:0] e;
    if (RST === 1'b0 && heard_ena === 1'b1) begin
      heard_cnt++;
      if (sb.size() == 0) begin
        chk("unexpected_heard", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("heard_data", {heard_meth, heard_v}, e);
      end
    end
  end

  task automatic drive(input logic ena, input logic [15:0] tag,
                       input logic [31:0] m, input logic [31:0] v,
                       input logic rdy, output logic a);
    @(posedge CLK);
    #1;
    enq_ena   = ena;
    enq_v     = {tag, m, v};
    heard_rdy = rdy;
    @(negedge CLK);
    a = ena && enq_rdy;
    if (a) begin
      if (tag == 16'd1) sb.push_back({m, v});
      else if (exp_drop != 16'hFFFF) exp_drop++;
    end
  endtask

  task automatic idle(input logic rdy);
    logic a;
    drive(1'b0, 16'd0, 32'd0, 32'd0, rdy, a);
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    RST = 1'b1;
    enq_ena = 1'b0;
    enq_v = '0;
    heard_rdy = 1'b1;
    repeat (2) @(negedge CLK);
    chk("rst_enq_rdy", enq_rdy, 1);
    chk("rst_heard_ena", heard_ena, 0);
    chk("rst_meth", heard_meth, 0);
    chk("rst_v", heard_v, 0);
    chk("rst_drop", drop_count, 0);
    @(posedge CLK);
    #1 RST = 1'b0;

    // single word, one cycle latency
    drive(1, 16'd1, 32'h5, 32'hA, 1, acc);
    chk("t1_acc", acc, 1);
    idle(1);
    chk("t1_heard_ena", heard_ena, 1);
    chk("t1_meth", heard_meth, 32'h5);
    chk("t1_v", heard_v, 32'hA);
    idle(1);
    chk("t1_empty_ena", heard_ena, 0);
    chk("t1_empty_rdy", enq_rdy, 1);
    chk("t1_empty_meth", heard_meth, 0);
    chk("t1_empty_v", heard_v, 0);

    // backpressure, fill to full
    h0 = heard_cnt;
    drive(1, 16'd1, 32'h11, 32'h101, 0, acc);
    chk("t2_acc1", acc, 1);
    drive(1, 16'd1, 32'h22, 32'h202, 0, acc);
    chk("t2_acc2", acc, 1);
    drive(1, 16'd1, 32'h33, 32'h303, 0, acc);
    chk("t2_full_rdy", acc, 0);
    chk("t2_hold_ena", heard_ena, 0);
    chk("t2_hold_meth", heard_meth, 32'h11);
    idle(0);
    chk("t2_still_full", enq_rdy, 0);
    chk("t2_hold_v", heard_v, 32'h101);
    idle(1);
    chk("t2_first", heard_meth, 32'h11);
    idle(1);
    chk("t2_second", heard_meth, 32'h22);
    chk("t2_second_ena", heard_ena, 1);
    idle(1);
    chk("t2_done", heard_ena, 0);
    chk("t2_count", heard_cnt - h0, 2);

    // bad tag then good tag
    h0 = heard_cnt;
    drive(1, 16'd7, 32'h9, 32'h9, 1, acc);
    drive(1, 16'd1, 32'h0, 32'h3, 1, acc);
    repeat (3) idle(1);
    chk("t3_drop", drop_count, exp_drop);
    chk("t3_drop_one", drop_count, 1);
    chk("t3_count", heard_cnt - h0, 1);

    // full then streaming
    drive(1, 16'd1, 32'h40, 32'h400, 0, acc);
    drive(1, 16'd1, 32'h41, 32'h401, 0, acc);
    for (int i = 0; i < 8; i++) begin
      drive(1, 16'd1, 32'h50 + i, 32'h500 + i, 1, acc);
      chk("t4_rdy", acc, (i == 0) ? 1'b0 : 1'b1);
      chk("t4_heard", heard_ena, 1);
    end
    repeat (3) idle(1);
    chk("t4_empty", enq_rdy, 1);
    chk("t4_sb", sb.size(), 0);

    // async reset while full
    drive(1, 16'd1, 32'h60, 32'h600, 0, acc);
    drive(1, 16'd1, 32'h61, 32'h601, 0, acc);
    idle(0);
    chk("t5_full", enq_rdy, 0);
    @(posedge CLK);
    #2;
    heard_rdy = 1'b1;
    RST = 1'b1;
    #1;
    chk("t5_rst_ena", heard_ena, 0);
    chk("t5_rst_rdy", enq_rdy, 1);
    chk("t5_rst_drop", drop_count, 0);
    sb.delete();
    exp_drop = 16'd0;
    @(negedge CLK);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    enq_ena = 1'b1;
    enq_v = {16'd1, 32'h70, 32'h700};
    sb.push_back({32'h70, 32'h700});
    @(negedge CLK);
    chk("t5_first_rdy", enq_rdy, 1);
    @(posedge CLK);
    #1 enq_ena = 1'b0;
    @(negedge CLK);
    chk("t5_first_heard", heard_ena, 1);
    chk("t5_first_meth", heard_meth, 32'h70);
    repeat (3) idle(1);
    chk("t5_sb", sb.size(), 0);

    // drop counter saturation through real traffic
    while (exp_drop != 16'hFFFE)
      drive(1, 16'd7, 32'h0, 32'h0, 1, acc);
    repeat (2) idle(1);
    chk("t6_fffe", drop_count, 16'hFFFE);
    drive(1, 16'd7, 32'h1, 32'h1, 1, acc);
    repeat (2) idle(1);
    chk("t6_ffff", drop_count, 16'hFFFF);
    drive(1, 16'd9, 32'h2, 32'h2, 1, acc);
    repeat (2) idle(1);
    chk("t6_sat", drop_count, 16'hFFFF);
    chk("t6_model", drop_count, exp_drop);

    chk("final_sb", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
